// File: rtl/multiexp_feeder.sv
// Source-side sequencer for multiexp_core: buffers a batch of {point, scalar} pairs, replays it
// SCL_BITS times and forwards the result. Optional stall counter: MULTIEXP_FEEDER_STALL_CNT_EN.
module multiexp_feeder #(
    parameter int NUM_IN   = 2,
    parameter int PNT_BITS = 768,
    parameter int SCL_BITS = 256,
    parameter int CTL_BITS = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [PNT_BITS+SCL_BITS-1:0] load_dat,
    input  logic                         load_val,
    input  logic                         load_eop,
    output logic                         load_rdy,
    output logic [PNT_BITS+SCL_BITS-1:0] pnt_scl_dat,
    output logic [CTL_BITS-1:0]          pnt_scl_ctl,
    output logic                         pnt_scl_sop,
    output logic                         pnt_scl_eop,
    output logic                         pnt_scl_val,
    input  logic                         pnt_scl_rdy,
    input  logic [PNT_BITS-1:0]          res_in_dat,
    input  logic                         res_in_val,
    output logic                         res_in_rdy,
    output logic [PNT_BITS-1:0]          res_out_dat,
    output logic [CTL_BITS-1:0]          res_out_ctl,
    output logic                         res_out_sop,
    output logic                         res_out_eop,
    output logic                         res_out_val,
    input  logic                         res_out_rdy,
    output logic                         o_err,
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    output logic [31:0]                  o_stall_cnt,
`endif
    output logic                         o_busy
);

    localparam int DW = PNT_BITS + SCL_BITS;
    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int RW = $clog2(SCL_BITS + 1);

    typedef enum logic [1:0] {LOAD, REPLAY, WAIT_RES, SEND_RES} state_t;

    state_t          state;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   idx;
    logic [RW-1:0]   rnd;
    logic [DW-1:0]   pair_buf [NUM_IN];

    logic            load_fire;
    logic            wr_last;
    logic            idx_last;
    logic            rnd_last;
    logic [IW-1:0]   idx_nxt;

    assign load_fire = load_val && load_rdy;
    assign wr_last   = (wr_idx == IW'(NUM_IN - 1));
    assign idx_last  = (idx == IW'(NUM_IN - 1));
    assign rnd_last  = (rnd == RW'(SCL_BITS - 1));
    assign idx_nxt   = idx_last ? '0 : idx + IW'(1);

    assign pnt_scl_ctl = CTL_BITS'(idx);
    assign pnt_scl_sop = 1'b1;
    assign pnt_scl_eop = 1'b1;
    assign res_out_ctl = '0;
    assign res_out_sop = 1'b1;
    assign res_out_eop = 1'b1;

    // NOTE: the pair buffer is plain storage with no reset; only control state is reset.
    always_ff @(posedge i_clk) begin
        if (load_fire) pair_buf[wr_idx] <= load_dat;
    end

    // Outputs are registered; the replay data register is preloaded with the next pair on each
    // handshake so it stays stable through any stall.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= LOAD;
            wr_idx      <= '0;
            idx         <= '0;
            rnd         <= '0;
            load_rdy    <= 1'b1;
            pnt_scl_val <= 1'b0;
            pnt_scl_dat <= '0;
            res_in_rdy  <= 1'b0;
            res_out_val <= 1'b0;
            res_out_dat <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every branch sees pre-edge values.
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        if (load_eop != wr_last) o_err <= 1'b1;
                        if (wr_last) begin
                            state       <= REPLAY;
                            wr_idx      <= '0;
                            idx         <= '0;
                            rnd         <= '0;
                            load_rdy    <= 1'b0;
                            pnt_scl_val <= 1'b1;
                            o_busy      <= 1'b1;
                            pnt_scl_dat <= (NUM_IN == 1) ? load_dat : pair_buf[0];
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                REPLAY: begin
                    if (pnt_scl_rdy) begin
                        idx         <= idx_nxt;
                        pnt_scl_dat <= pair_buf[idx_nxt];
                        if (idx_last) begin
                            if (rnd_last) begin
                                state       <= WAIT_RES;
                                pnt_scl_val <= 1'b0;
                                res_in_rdy  <= 1'b1;
                            end else begin
                                rnd <= rnd + RW'(1);
                            end
                        end
                    end
                end
                WAIT_RES: begin
                    if (res_in_val) begin
                        state       <= SEND_RES;
                        res_out_dat <= res_in_dat;
                        res_in_rdy  <= 1'b0;
                        res_out_val <= 1'b1;
                    end
                end
                SEND_RES: begin
                    if (res_out_rdy) begin
                        state       <= LOAD;
                        wr_idx      <= '0;
                        res_out_val <= 1'b0;
                        load_rdy    <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_stall_cnt <= '0;
        end else if (state == LOAD && load_fire && wr_last) begin
            o_stall_cnt <= '0;
        end else if (state == REPLAY && pnt_scl_val && !pnt_scl_rdy && o_stall_cnt != '1) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multiexp_feeder.sv
// Scoreboard bench for multiexp_feeder: expected replay beats and results are queued at load time
// and popped as the DUT hands them over.
module tb_multiexp_feeder;

    localparam int NUM_IN   = 2;
    localparam int PNT_BITS = 768;
    localparam int SCL_BITS = 256;
    localparam int CTL_BITS = 8;
    localparam int DW       = PNT_BITS + SCL_BITS;

    typedef struct {
        logic [CTL_BITS-1:0] ctl;
        logic [DW-1:0]       dat;
    } beat_t;

    logic                i_clk;
    logic                i_rst;
    logic [DW-1:0]       load_dat;
    logic                load_val;
    logic                load_eop;
    logic                load_rdy;
    logic [DW-1:0]       pnt_scl_dat;
    logic [CTL_BITS-1:0] pnt_scl_ctl;
    logic                pnt_scl_sop;
    logic                pnt_scl_eop;
    logic                pnt_scl_val;
    logic                pnt_scl_rdy;
    logic [PNT_BITS-1:0] res_in_dat;
    logic                res_in_val;
    logic                res_in_rdy;
    logic [PNT_BITS-1:0] res_out_dat;
    logic [CTL_BITS-1:0] res_out_ctl;
    logic                res_out_sop;
    logic                res_out_eop;
    logic                res_out_val;
    logic                res_out_rdy;
    logic                o_err;
    logic                o_busy;
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
    logic [31:0]         o_stall_cnt;
`endif

    beat_t               exp_q[$];
    logic [PNT_BITS-1:0] res_q[$];
    int                  total = 0;
    int                  bad   = 0;

    multiexp_feeder #(
        .NUM_IN(NUM_IN), .PNT_BITS(PNT_BITS), .SCL_BITS(SCL_BITS), .CTL_BITS(CTL_BITS)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .load_dat(load_dat), .load_val(load_val), .load_eop(load_eop), .load_rdy(load_rdy),
        .pnt_scl_dat(pnt_scl_dat), .pnt_scl_ctl(pnt_scl_ctl), .pnt_scl_sop(pnt_scl_sop),
        .pnt_scl_eop(pnt_scl_eop), .pnt_scl_val(pnt_scl_val), .pnt_scl_rdy(pnt_scl_rdy),
        .res_in_dat(res_in_dat), .res_in_val(res_in_val), .res_in_rdy(res_in_rdy),
        .res_out_dat(res_out_dat), .res_out_ctl(res_out_ctl), .res_out_sop(res_out_sop),
        .res_out_eop(res_out_eop), .res_out_val(res_out_val), .res_out_rdy(res_out_rdy),
        .o_err(o_err),
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
        .o_stall_cnt(o_stall_cnt),
`endif
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [PNT_BITS-1:0] rand_pnt();
        logic [PNT_BITS-1:0] p;
        for (int k = 0; k < PNT_BITS / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [DW-1:0] rand_pair();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic load_beat(input logic [DW-1:0] d, input logic eop);
        int n = 0;
        load_dat = d;
        load_eop = eop;
        load_val = 1'b1;
        while (load_rdy !== 1'b1 && n < 1000) begin
            @(posedge i_clk); #1;
            n++;
        end
        total++;
        if (load_rdy !== 1'b1) begin
            bad++;
            $display("FAIL load_rdy_timeout: rdy=%b required 1", load_rdy);
        end
        @(posedge i_clk); #1;
        load_val = 1'b0;
        load_eop = 1'b0;
    endtask

    // Loads two pairs and queues the full expected replay sequence.
    task automatic load_batch(input logic [DW-1:0] p0, input logic [DW-1:0] p1, input logic eop0);
        beat_t b;
        load_beat(p0, eop0);
        total++;
        if (pnt_scl_val !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_load: val=%b busy=%b required 0 0", pnt_scl_val, o_busy);
        end
        load_beat(p1, 1'b1);
        total++;
        if (pnt_scl_val !== 1'b1 || o_busy !== 1'b1 || load_rdy !== 1'b0) begin
            bad++;
            $display("FAIL replay_start: val=%b busy=%b load_rdy=%b required 1 1 0",
                     pnt_scl_val, o_busy, load_rdy);
        end
        for (int r = 0; r < SCL_BITS; r++) begin
            b.ctl = 8'd0; b.dat = p0; exp_q.push_back(b);
            b.ctl = 8'd1; b.dat = p1; exp_q.push_back(b);
        end
    endtask

    task automatic run_replay(input int rdy_pct, input int max_beats, output int stalls);
        int    beats = 0;
        int    cyc   = 0;
        logic  held  = 1'b0;
        logic [DW-1:0]       held_dat;
        logic [CTL_BITS-1:0] held_ctl;
        beat_t e;
        stalls = 0;
        while (exp_q.size() > 0 && beats < max_beats && cyc < 20000) begin
            pnt_scl_rdy = ($urandom_range(0, 99) < rdy_pct);
            total++;
            if (pnt_scl_val !== 1'b1) begin
                bad++;
                $display("FAIL replay_val: val=%b required 1 at beat %0d", pnt_scl_val, beats);
            end else begin
                if (held) begin
                    total++;
                    if (pnt_scl_dat !== held_dat || pnt_scl_ctl !== held_ctl) begin
                        bad++;
                        $display("FAIL stall_stable: ctl=%0d dat=%h required ctl=%0d dat=%h",
                                 pnt_scl_ctl, pnt_scl_dat[63:0], held_ctl, held_dat[63:0]);
                    end
                end
                if (pnt_scl_rdy) begin
                    e = exp_q.pop_front();
                    total++;
                    if (pnt_scl_ctl !== e.ctl || pnt_scl_dat !== e.dat ||
                        pnt_scl_sop !== 1'b1 || pnt_scl_eop !== 1'b1) begin
                        bad++;
                        $display("FAIL beat %0d: ctl=%0d dat=%h sop=%b eop=%b required ctl=%0d dat=%h",
                                 beats, pnt_scl_ctl, pnt_scl_dat[63:0], pnt_scl_sop, pnt_scl_eop,
                                 e.ctl, e.dat[63:0]);
                    end
                    beats++;
                    held = 1'b0;
                end else begin
                    stalls++;
                    held     = 1'b1;
                    held_dat = pnt_scl_dat;
                    held_ctl = pnt_scl_ctl;
                end
            end
            if (res_in_val) begin
                total++;
                if (res_in_rdy !== 1'b0) begin
                    bad++;
                    $display("FAIL early_res_rdy: rdy=%b required 0 at beat %0d", res_in_rdy, beats);
                end
            end
            @(posedge i_clk); #1;
            cyc++;
        end
        pnt_scl_rdy = 1'b0;
        total++;
        if (cyc >= 20000) begin
            bad++;
            $display("FAIL replay_timeout: beats=%0d required %0d", beats, max_beats);
        end
    endtask

    task automatic check_replay_end();
        total++;
        if (pnt_scl_val !== 1'b0 || res_in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL replay_end: val=%b res_in_rdy=%b required 0 1", pnt_scl_val, res_in_rdy);
        end
    endtask

    task automatic get_result(input logic [PNT_BITS-1:0] r, input int rdy_pct);
        int n = 0;
        logic [PNT_BITS-1:0] e;
        res_in_dat = r;
        res_in_val = 1'b1;
        res_q.push_back(r);
        @(posedge i_clk); #1;
        res_in_val = 1'b0;
        total++;
        if (res_out_val !== 1'b1 || res_in_rdy !== 1'b0) begin
            bad++;
            $display("FAIL res_capture: res_out_val=%b res_in_rdy=%b required 1 0", res_out_val, res_in_rdy);
        end
        while (res_q.size() > 0 && n < 200) begin
            res_out_rdy = ($urandom_range(0, 99) < rdy_pct);
            total++;
            if (res_out_val !== 1'b1 || res_out_dat !== res_q[0] ||
                res_out_sop !== 1'b1 || res_out_eop !== 1'b1) begin
                bad++;
                $display("FAIL res_out: val=%b dat=%h required 1 %h", res_out_val, res_out_dat[63:0],
                         res_q[0][63:0]);
            end
            if (res_out_rdy) e = res_q.pop_front();
            @(posedge i_clk); #1;
            n++;
        end
        res_out_rdy = 1'b0;
        total++;
        if (res_q.size() != 0 || load_rdy !== 1'b1 || o_busy !== 1'b0 || res_out_val !== 1'b0) begin
            bad++;
            $display("FAIL res_done: pending=%0d load_rdy=%b busy=%b val=%b required 0 1 0 0",
                     res_q.size(), load_rdy, o_busy, res_out_val);
        end
        res_q.delete();
    endtask

    task automatic check_stalls(input int stalls);
`ifdef MULTIEXP_FEEDER_STALL_CNT_EN
        total++;
        if (o_stall_cnt !== 32'(stalls)) begin
            bad++;
            $display("FAIL stall_cnt: got=%0d required %0d", o_stall_cnt, stalls);
        end
`else
        if (stalls < 0) $display("negative stall count");
`endif
    endtask

    task automatic test_reset();
        load_val = 0; load_eop = 0; load_dat = '0;
        pnt_scl_rdy = 0; res_in_val = 0; res_in_dat = '0; res_out_rdy = 0;
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        total++;
        if (pnt_scl_val !== 0 || res_out_val !== 0 || res_in_rdy !== 0 || o_err !== 0 || o_busy !== 0) begin
            bad++;
            $display("FAIL reset_state: val=%b res_val=%b res_rdy=%b err=%b busy=%b required all 0",
                     pnt_scl_val, res_out_val, res_in_rdy, o_err, o_busy);
        end
        @(negedge i_clk) i_rst = 1'b1;
        @(posedge i_clk); #1;
        total++;
        if (load_rdy !== 1'b1 || pnt_scl_val !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: load_rdy=%b val=%b required 1 0", load_rdy, pnt_scl_val);
        end
    endtask

    task automatic test_basic();
        int st;
        logic [DW-1:0] p0 = {rand_pnt(), SCL_BITS'(5)};
        logic [DW-1:0] p1 = {rand_pnt(), SCL_BITS'(9)};
        load_batch(p0, p1, 1'b0);
        run_replay(100, 1 << 30, st);
        check_replay_end();
        check_stalls(st);
        get_result(rand_pnt(), 100);
    endtask

    task automatic test_back_pressure();
        int st;
        load_batch(rand_pair(), rand_pair(), 1'b0);
        run_replay(50, 1 << 30, st);
        check_replay_end();
        check_stalls(st);
        get_result(rand_pnt(), 50);
    endtask

    task automatic test_early_result();
        int st;
        logic [PNT_BITS-1:0] r = rand_pnt();
        load_batch(rand_pair(), rand_pair(), 1'b0);
        res_in_dat = r;
        res_in_val = 1'b1;
        run_replay(70, 1 << 30, st);
        check_replay_end();
        get_result(r, 100);
    endtask

    task automatic test_framing_error();
        int st;
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("FAIL err_before: err=%b required 0", o_err);
        end
        load_batch(rand_pair(), rand_pair(), 1'b1);
        total++;
        if (o_err !== 1'b1) begin
            bad++;
            $display("FAIL framing_err: err=%b required 1", o_err);
        end
        run_replay(100, 1 << 30, st);
        check_replay_end();
        get_result(rand_pnt(), 100);
        total++;
        if (o_err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err=%b required 1", o_err);
        end
    endtask

    task automatic test_reset_mid_replay();
        int st;
        load_batch(rand_pair(), rand_pair(), 1'b0);
        run_replay(100, 100, st);
        i_rst = 1'b0;
        #1;
        total++;
        if (pnt_scl_val !== 0 || res_out_val !== 0 || o_busy !== 0 || o_err !== 0 || res_in_rdy !== 0) begin
            bad++;
            $display("FAIL mid_reset: val=%b res_val=%b busy=%b err=%b res_rdy=%b required all 0",
                     pnt_scl_val, res_out_val, o_busy, o_err, res_in_rdy);
        end
        exp_q.delete();
        @(negedge i_clk) i_rst = 1'b1;
        @(posedge i_clk); #1;
        total++;
        if (load_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_load_rdy: rdy=%b required 1", load_rdy);
        end
        load_batch(rand_pair(), rand_pair(), 1'b0);
        run_replay(80, 1 << 30, st);
        check_replay_end();
        check_stalls(st);
        get_result(rand_pnt(), 60);
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("FAIL err_after_clean: err=%b required 0", o_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_early_result();
        test_framing_error();
        test_reset_mid_replay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiexp_feeder.md
# multiexp_feeder

Source-side sequencer for `multiexp_core`.
- Accepts a batch of NUM_IN {point, scalar} pairs and stores them locally.
- Replays the batch SCL_BITS times, round-robin, onto the core's point/scalar input stream.
- Collects the single Jacobian result point from the core and forwards it downstream.
- Sits between the host/DMA loader and `multiexp_core`, replacing the bench-driven stimulus with synthesizable RTL.

## Interface
Parameters:
- NUM_IN, 2, pairs per batch; 1..2**CTL_BITS.
- PNT_BITS, 768, Jacobian point width (3 × 256-bit fe_t).
- SCL_BITS, 256, scalar width; also the replay round count.
- CTL_BITS, 8, ctl field width on all streams.

Ports (all streams are `if_axi_stream`; a beat transfers when val && rdy):
- Clocking and reset: one clock; reset is asynchronous and active-low.
- i_clk, input, 1, clock.
- i_rst, input, 1, asynchronous active-low reset.
- i_load_if, sink, dat = PNT_BITS+SCL_BITS, one pair per beat; dat = {pnt, scl}, point in the upper bits.
- o_pnt_scl_if, source, dat = PNT_BITS+SCL_BITS, to core; ctl = pair index; sop = eop = 1 on every beat.
- i_res_if, sink, dat = PNT_BITS, result from core.
- o_res_if, source, dat = PNT_BITS, result to downstream; sop = eop = 1.
- o_err, output, 1, sticky load-framing error; cleared only by reset.
- o_busy, output, 1, high in any state other than LOAD.

## Operation
State LOAD:
- i_load_if.rdy = 1.
- Each beat writes entry wr_idx, then wr_idx increments.
- After beat NUM_IN-1, go to REPLAY with rnd = 0 and idx = 0.
- eop on a beat other than NUM_IN-1, or missing on beat NUM_IN-1, sets o_err. Loading still ends at exactly NUM_IN beats.

State REPLAY:
- o_pnt_scl_if.val = 1.
- dat = {pnt[idx], scl[idx]}, ctl = idx.
- On each handshake, idx increments. When idx wraps from NUM_IN-1 to 0, rnd increments.
- After the handshake with rnd = SCL_BITS-1 and idx = NUM_IN-1, go to WAIT_RES.
- Total beats: SCL_BITS × NUM_IN. The scalar is sent unmodified every round.

State WAIT_RES:
- i_res_if.rdy = 1.
- On handshake, capture dat into the result register and go to SEND_RES.

State SEND_RES:
- o_res_if.val = 1 with the captured point.
- On handshake, go to LOAD with wr_idx = 0.

Ready outside owning state:
- i_load_if.rdy is 0 outside LOAD.
- i_res_if.rdy is 0 outside WAIT_RES.
- Upstream data offered early is therefore held, never dropped.

Storage:
- Point/scalar buffer: NUM_IN × (PNT_BITS+SCL_BITS) registers. It is not cleared by reset; contents are undefined until loaded.
- rnd counter: $clog2(SCL_BITS+1) bits.
- idx and wr_idx counters: max($clog2(NUM_IN), 1) bits.

## Timing
Reset values:
- State = LOAD.
- All val = 0.
- i_load_if.rdy = 1 on the first cycle after reset release.
- i_res_if.rdy = 0.
- o_err = 0, o_busy = 0.
- Counters = 0.

Reset mid-operation (any state): immediately returns to the above. Any partially sent batch is abandoned; the core must be reset together with this block.

Latency:
- Last load handshake at cycle t → o_pnt_scl_if.val = 1 at t+1.
- Back-to-back replay beats at 1 beat/cycle while rdy stays high.
- Last replay handshake at t → i_res_if.rdy = 1 at t+1.
- Result handshake at t → o_res_if.val = 1 at t+1.
- o_res_if handshake at t → i_load_if.rdy = 1 at t+1.

Handshake rules:
- All source outputs are registered.
- While val = 1 and rdy = 0, dat, ctl, sop and eop remain stable.
- val never drops without a handshake.

NUM_IN = 1: idx stays at 0, and rnd increments on every beat.

## Configuration
- Macro MULTIEXP_FEEDER_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt, 32 bits.
  - Counts cycles in REPLAY with o_pnt_scl_if.val = 1 and rdy = 0.
  - Saturates at 2^32-1.
  - Cleared on reset and on entry to REPLAY.
- Undefined: the port and counter are absent, with no other behavioural difference.

## Test plan
- Basic batch:
  - Stimulus: NUM_IN = 2; load pairs {P0, s0 = 5}, {P1, s1 = 9}; core stub always ready.
  - Expect exactly 512 beats in order ctl = 0,1,0,1,…, with dat matching the stored pairs.
  - Stub returns point R → o_res_if carries R one cycle after acceptance.
- Backpressure:
  - Stimulus: random 50% rdy on o_pnt_scl_if and o_res_if.
  - Expect no beat lost or duplicated and dat stable during stalls.
  - With the macro defined, o_stall_cnt equals the stall cycles counted by the bench.
- Framing error:
  - Stimulus: eop on load beat 0 of 2.
  - Expect o_err = 1, loading still takes 2 beats, and replay proceeds normally.
- Early result:
  - Stimulus: stub asserts i_res_if.val during REPLAY.
  - Expect i_res_if.rdy = 0 until the 512th beat, then the result is accepted at the next cycle.
- Reset mid-replay:
  - Stimulus: assert i_rst low after beat 100.
  - Expect all val = 0 and o_busy = 0 immediately.
  - A new 2-pair batch then produces a full 512-beat replay starting at ctl = 0.
- Full system check:
  - Stimulus: drive `multiexp_core` plus the field mult/add/sub pipes, with NUM_IN = 2 and random scalars mod P.
  - Expect to_affine(result) == to_affine(multiexp_batch(s, p)).
